mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline.
- Owns the architectural HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Multi-cycle latency is modelled with a busy counter.
- The hazard unit uses `busy` and `start` to stall any MD-class instruction in Decode.
- mfhi/mflo read `hi`/`lo` directly as an Execute-stage result.

Parameters:
- MULT_CYCLES, default 5: busy cycles for mult/multu.
- DIV_CYCLES, default 10: busy cycles for div/divu.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  Execute-stage instruction is an MD operation this cycle.
- md_op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  input  32  rs operand, post-forwarding.
- b  input  32  rt operand, post-forwarding.
- busy  output  1  multi-cycle operation in progress.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset: on a rising edge with reset=1:
  - hi=0, lo=0, busy=0, internal counter=0, pending result=0.
  - Reset overrides start in the same cycle.
  - Reset during an operation aborts it; HI/LO stay 0.
- Accept rule: an operation is accepted on an edge where reset=0, start=1 and busy=0. If busy=1, start is ignored and no state changes; the hazard unit guarantees this does not happen.
- mthi/mtlo:
  - On acceptance, hi<=a (mthi) or lo<=a (mtlo) at that edge.
  - busy stays 0; the new value is visible the next cycle.
- mult/multu accept edge T0:
  - Pending {hi,lo} <= 64-bit product of a and b: signed for mult, unsigned for multu.
  - Counter <= MULT_CYCLES and busy=1 from T0+1.
- div/divu accept edge T0:
  - Pending lo <= quotient, pending hi <= remainder; signed for div, unsigned for divu.
  - Counter <= DIV_CYCLES and busy=1 from T0+1.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Counting and commit:
  - While counter>0, it decrements by 1 each edge; busy = (counter != 0), registered.
  - On the edge where counter goes 1→0, pending values commit to hi/lo and busy drops.
  - Net timing: busy is high for exactly N cycles (T0+1..T0+N). New hi/lo are visible from T0+N+1, in the same cycle busy reads 0.
  - hi/lo keep their old values while busy=1.
- Divide by zero (b=0, div or divu):
  - Operation still runs for DIV_CYCLES with busy asserted.
  - On commit, hi and lo keep their prior values; no exception is raised.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): commits lo=0x80000000, hi=0.
- md_op=0 or 7 with start=1: no effect.
- Outputs: hi, lo and busy are direct register outputs with no combinational path from inputs.
- Hazard contract, enforced outside this block: the stall condition is (busy | start) & MD-class instruction in Decode. This block has no stall or flush inputs.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo hold their old values on every cycle busy=1.
- multu, a=0xFFFFFFFF, b=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. div a=0xFFFFFFF9 (-7), b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles → busy stays 0; hi=0x12345678, lo=0x9ABCDEF0 one cycle after each edge.
- Preload hi=0xAA, lo=0xBB, then div with b=0 → busy for 10 cycles; after commit hi=0xAA, lo=0xBB unchanged.
- Assert start with mult while busy from a prior div → second request ignored; only the div result commits, after exactly 10 cycles from its own accept.
- Start mult, assert reset on the 3rd busy cycle → next cycle busy=0, hi=0, lo=0; counter does not resume after reset deasserts.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Results are computed at accept time and held pending until a busy counter expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   pend_hi_reg, pend_hi_next;
  logic [31:0]   pend_lo_reg, pend_lo_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          busy_reg, busy_next;
  logic          commit_reg, commit_next;

  // Arithmetic datapath, evaluated on the operands presented at accept time.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, div_u_den, div_s_den;
  logic [31:0] quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

  always_comb begin
    prod_u    = {32'b0, a} * {32'b0, b};
    prod_s    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    a_neg     = a[31];
    b_neg     = b[31];
    a_mag     = a_neg ? (32'd0 - a) : a;
    b_mag     = b_neg ? (32'd0 - b) : b;
    b_zero    = (b == 32'd0);
    // Dummy divisor of 1 keeps the divider defined; the result is discarded on commit.
    div_u_den = b_zero ? 32'd1 : b;
    div_s_den = b_zero ? 32'd1 : b_mag;
    quo_u     = a / div_u_den;
    rem_u     = a % div_u_den;
    quo_m     = a_mag / div_s_den;
    rem_m     = a_mag % div_s_den;
    quo_s     = (a_neg ^ b_neg) ? (32'd0 - quo_m) : quo_m;
    rem_s     = a_neg ? (32'd0 - rem_m) : rem_m;
  end

  always_comb begin
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    cnt_next     = cnt_reg;
    commit_next  = commit_reg;

    if (busy_reg) begin
      // Requests while busy are dropped; only the countdown advances.
      cnt_next = cnt_reg - CW'(1);
      if (cnt_reg == CW'(1) && commit_reg) begin
        hi_next = pend_hi_reg;
        lo_next = pend_lo_reg;
      end
    end else if (start) begin
      case (md_op_t'(md_op))
        OP_MULT: begin
          {pend_hi_next, pend_lo_next} = prod_s;
          cnt_next    = CW'(MULT_CYCLES);
          commit_next = 1'b1;
        end
        OP_MULTU: begin
          {pend_hi_next, pend_lo_next} = prod_u;
          cnt_next    = CW'(MULT_CYCLES);
          commit_next = 1'b1;
        end
        OP_DIV: begin
          pend_lo_next = quo_s;
          pend_hi_next = rem_s;
          cnt_next     = CW'(DIV_CYCLES);
          commit_next  = !b_zero;
        end
        OP_DIVU: begin
          pend_lo_next = quo_u;
          pend_hi_next = rem_u;
          cnt_next     = CW'(DIV_CYCLES);
          commit_next  = !b_zero;
        end
        OP_MTHI: hi_next = a;
        OP_MTLO: lo_next = a;
        default: ;
      endcase
    end

    busy_next = (cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg      <= '0;
      lo_reg      <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      commit_reg  <= 1'b0;
    end else begin
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      commit_reg  <= commit_next;
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: vector table plus hand-built sequences for mthi/mtlo,
// divide-by-zero, ignored requests while busy, and reset abort.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, verify HI/LO hold while busy, then pop and compare the commit.
  // inj >= 0 raises a competing mult request during that busy cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int cyc, input int inj);
    logic [31:0] old_hi, old_lo;
    exp_t e;
    int n;
    old_hi = hi;
    old_lo = lo;
    @(negedge clk);
    start = 1'b1; md_op = op; a = av; b = bv;
    exp_q.push_back('{hi: eh, lo: el, cyc: cyc});
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    n = 0;
    while (busy && n < 200) begin
      chk({name, " hold_hi"}, hi, old_hi);
      chk({name, " hold_lo"}, lo, old_lo);
      if (n == inj) begin
        start = 1'b1; md_op = 3'd1; a = 32'd5; b = 32'd7;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0; md_op = 3'd0;
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL %s timeout: busy still high after %0d cycles", name, n);
    end
    e = exp_q.pop_front();
    chk({name, " busy_cycles"}, 32'(n), 32'(e.cyc));
    chk({name, " hi"}, hi, e.hi);
    chk({name, " lo"}, lo, e.lo);
    $display("op %-10s a=0x%08h b=0x%08h -> busy=%0d hi=0x%08h lo=0x%08h", name, av, bv, n, hi, lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; md_op = 3'd5; a = 32'hDEADBEEF; b = 32'd0;
    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{3'd7, 32'h55555555, 32'd9,        32'h00000001, 32'hFFFFFFFD, 0};

    // Reset with start asserted: reset must win.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; md_op = 3'd0;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    $display("reset -> busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc, -1);

    // Back-to-back moves into HI then LO.
    run_op("mthi", 3'd5, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFD, 0, -1);
    run_op("mtlo", 3'd6, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 0, -1);

    // Divide by zero leaves preloaded HI/LO untouched.
    run_op("pre_hi", 3'd5, 32'hAA, 32'd0, 32'hAA, 32'h9ABCDEF0, 0, -1);
    run_op("pre_lo", 3'd6, 32'hBB, 32'd0, 32'hAA, 32'hBB, 0, -1);
    run_op("div0", 3'd3, 32'd100, 32'd0, 32'hAA, 32'hBB, 10, -1);
    run_op("divu0", 3'd4, 32'd100, 32'd0, 32'hAA, 32'hBB, 10, -1);

    // A mult request arriving mid-divide is ignored.
    run_op("div_ign", 3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 2);
    repeat (3) begin
      @(posedge clk); #1;
      chk("ign idle busy", {31'b0, busy}, 32'd0);
    end
    chk("ign hi", hi, 32'hFFFFFFFF);
    chk("ign lo", lo, 32'hFFFFFFFD);

    // Reset on the third busy cycle of a mult aborts it for good.
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    chk("abort busy1", {31'b0, busy}, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort busy3", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    $display("abort -> busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post busy", {31'b0, busy}, 32'd0);
    end
    chk("post hi", hi, 32'd0);
    chk("post lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
